ps2_kbd_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 66 ++++++
 rtl/ps2_kbd_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard transmitter.
// Optional build macro used by the top level: PS2_HOST_INHIBIT_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } ps2_state_t;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;
  // Ticks per bit cell: data set, clock low, hold low, clock high.
  localparam int PS2_QUARTERS   = 4;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO feeding the PS/2 serialiser. Registered storage and occupancy;
// a push rejected when full is simply ignored here (the top flags overflow).
module ps2_byte_fifo
#(
  parameter int DEPTH = 16
)
(
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full is judged on registered occupancy, so a push and pop in the same
  // cycle while full still rejects the push.
  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan-code bytes and sends
// each as an 11-bit frame on idle-high clock/data lines.
// Build option PS2_HOST_INHIBIT_EN adds ps2_clk_in so the host can hold the
// clock low to inhibit/abort transmission; the interrupted byte is resent.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | lines high, divider parked at 0, waiting for a byte
// START | bit cell 0 (start bit) of the current frame
// SHIFT | bit cells 1-10: data LSB first, parity, stop
// GAP   | both lines high for GAP_TICKS ticks before the next frame
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int PS2_DIV    = 1000,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_TICKS  = 8
)
(
  input  logic                          clk,
  input  logic                          n_reset,
`ifdef PS2_HOST_INHIBIT_EN
  input  logic                          ps2_clk_in,
`endif
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk_out,
  output logic                          ps2_dat_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DW = (PS2_DIV > 1) ? $clog2(PS2_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(PS2_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_TICKS - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(PS2_FRAME_BITS - 1);
  localparam logic [3:0]    PARITY_BIT = 4'(PS2_FRAME_BITS - 2);
  localparam logic [1:0]    Q_LAST     = 2'(PS2_QUARTERS - 1);

  ps2_state_t r_state;
  logic [DW-1:0] r_div;
  logic [1:0]    r_q;
  logic [3:0]    r_bit;
  logic [7:0]    r_byte;
  logic          r_par;
  logic [GW-1:0] r_gap;
  logic          r_retry;
  logic          r_clk_out;
  logic          r_dat_out;
  logic          r_busy;
  logic          r_overflow;

  logic          w_tick;
  logic          w_bus_free;
  logic          w_start;
  logic          w_pop;
  logic          w_abort;
  logic          w_frame_bit;
  logic [3:0]    w_bit_m1;
  logic [7:0]    w_rd_data;
  logic          w_full;
  logic          w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

`ifdef PS2_HOST_INHIBIT_EN
  logic [1:0] r_clk_sync;

  // Two-flop synchroniser for the host-driven bus clock level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_clk_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
    end
  end

  assign w_bus_free = r_clk_sync[1];
`else
  assign w_bus_free = 1'b1;
`endif

  assign w_tick  = (r_state != IDLE) && (r_div == DIV_LAST);
  // A pending retry takes priority over the FIFO so the aborted byte goes first.
  assign w_start = (r_state == IDLE) && w_bus_free && (r_retry || !w_empty);
  assign w_pop   = w_start && !r_retry;
  // Host inhibit is only honoured at clock-high quarters before the parity bit.
  assign w_abort = !w_bus_free && ((r_q == 2'd0) || (r_q == Q_LAST)) &&
                   (r_bit < PARITY_BIT);
  assign w_bit_m1 = r_bit - 4'd1;

  // Value of the frame bit selected by the bit index.
  always_comb begin
    w_frame_bit = 1'b1;
    if (r_bit == 4'd0) begin
      w_frame_bit = 1'b0;
    end else if (r_bit < PARITY_BIT) begin
      w_frame_bit = r_byte[w_bit_m1[2:0]];
    end else if (r_bit == PARITY_BIT) begin
      w_frame_bit = r_par;
    end
  end

  // Tick divider: parked at 0 in IDLE so the first tick of a frame lands
  // exactly PS2_DIV cycles after the pop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_div <= '0;
    end else if (r_state == IDLE) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Frame sequencer with registered line, busy and overflow outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_q        <= 2'd0;
      r_bit      <= 4'd0;
      r_byte     <= 8'd0;
      r_par      <= 1'b0;
      r_gap      <= '0;
      r_retry    <= 1'b0;
      r_clk_out  <= 1'b1;
      r_dat_out  <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= in_valid & w_full;
      r_busy     <= (r_state != IDLE) | (w_count != '0) | r_retry;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (!r_retry) begin
              r_byte <= w_rd_data;
              r_par  <= odd_parity(w_rd_data);
            end
            r_retry <= 1'b0;
            r_q     <= 2'd0;
            r_bit   <= 4'd0;
            r_state <= START;
          end
        end
        START, SHIFT: begin
          if (w_tick) begin
            if (w_abort) begin
              r_clk_out <= 1'b1;
              r_dat_out <= 1'b1;
              r_retry   <= 1'b1;
              r_gap     <= GAP_LOAD;
              r_state   <= GAP;
            end else begin
              r_q <= r_q + 2'd1;
              case (r_q)
                2'd0: r_dat_out <= w_frame_bit;
                2'd1: r_clk_out <= 1'b0;
                Q_LAST: begin
                  r_clk_out <= 1'b1;
                  if (r_bit == LAST_BIT) begin
                    r_gap   <= GAP_LOAD;
                    r_state <= GAP;
                  end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_state <= SHIFT;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            if (r_gap == '0) begin
              r_state <= IDLE;
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = ~w_full;
  assign fifo_count  = w_count;
  assign ps2_clk_out = r_clk_out;
  assign ps2_dat_out = r_dat_out;
  assign busy        = r_busy;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx with a transaction-level reference model.
module tb_ps2_kbd_tx;

  localparam int DIV   = 4;
  localparam int GAPT  = 2;
  localparam int DEPTH = 16;
  localparam int FRAME = (44 + GAPT) * DIV;

  logic       clk;
  logic       n_reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ps2_clk_out;
  logic       ps2_dat_out;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;
`ifdef PS2_HOST_INHIBIT_EN
  logic       ps2_clk_in = 1'b1;
`endif

  ps2_kbd_tx #(
    .PS2_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .GAP_TICKS  (GAPT)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
`ifdef PS2_HOST_INHIBIT_EN
    .ps2_clk_in  (ps2_clk_in),
`endif
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ps2_clk_out (ps2_clk_out),
    .ps2_dat_out (ps2_dat_out),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes queue up, and the link takes one byte at a time,
  // each occupying FRAME cycles plus one turnaround cycle.
  int         edge_n = 0;
  int         m_count = 0;
  logic [7:0] mq[$];
  logic [7:0] txq[$];
  int         popq[$];
  bit         have_pop = 0;
  int         last_pop = 0;
  int         next_free = 0;
  bit         exp_busy = 0;
  bit         exp_ovf = 0;
  bit         exp_ready = 1;

  task automatic model_clear();
    m_count = 0;
    mq.delete();
    txq.delete();
    popq.delete();
    have_pop = 0;
    next_free = 0;
    exp_busy = 0;
    exp_ovf = 0;
    exp_ready = 1;
  endtask

  task automatic model_step();
    bit pop, acc;
    if (!n_reset) begin
      model_clear();
      return;
    end
    exp_busy = (m_count != 0) || (have_pop && (edge_n - 1 < last_pop + FRAME));
    exp_ovf  = in_valid && (m_count == DEPTH);
    acc      = in_valid && (m_count < DEPTH);
    pop      = (m_count > 0) && (edge_n >= next_free);
    if (pop) begin
      txq.push_back(mq.pop_front());
      popq.push_back(edge_n);
      have_pop  = 1;
      last_pop  = edge_n;
      next_free = edge_n + FRAME + 1;
    end
    if (acc) mq.push_back(in_data);
    m_count   = m_count + int'(acc) - int'(pop);
    exp_ready = (m_count < DEPTH);
  endtask

  always @(posedge clk) begin
    edge_n++;
    model_step();
  end

  always @(negedge n_reset) model_clear();

  // Output checks and a line-level frame decoder, away from the active edge.
  int          nbits = 0;
  logic [10:0] bits;
  logic [10:0] last_frame = '0;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  int          last_fall = 0;
  int          fall_cnt = 0;
  int          ovf_seen = 0;
  int          max_cnt = 0;

  always @(negedge clk) begin
    logic [7:0] eb;
    chk("fifo_count", fifo_count, m_count);
    chk("in_ready", in_ready, exp_ready);
    chk("busy", busy, exp_busy);
    chk("overflow", overflow, exp_ovf);
    if (overflow) ovf_seen++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (!n_reset) begin
      nbits = 0;
      prev_clk = 1'b1;
      prev_dat = 1'b1;
    end else begin
      if (ps2_dat_out !== prev_dat)
        chk("dat_change_while_clk_high", {prev_clk, ps2_clk_out}, 2'b11);
      if (prev_clk && !ps2_clk_out) begin
        fall_cnt++;
        if (nbits == 0) begin
          chk("frame_expected", popq.size() > 0, 1);
          if (popq.size() > 0) chk("first_fall_time", edge_n, popq.pop_front() + 2 * DIV);
        end else begin
          chk("bit_spacing", edge_n - last_fall, 4 * DIV);
        end
        last_fall = edge_n;
        bits[nbits] = ps2_dat_out;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          last_frame = bits;
          chk("byte_expected", txq.size() > 0, 1);
          if (txq.size() > 0) begin
            eb = txq.pop_front();
            chk("frame_byte", bits[8:1], eb);
            chk("frame_parity", bits[9], ($countones(eb) % 2) == 0);
          end
          chk("start_bit", bits[0], 0);
          chk("stop_bit", bits[10], 1);
        end
      end
      prev_clk = ps2_clk_out;
      prev_dat = ps2_dat_out;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    while (!(m_count == 0 && txq.size() == 0 && !exp_busy) && k < limit) begin
      drive(1'b0, 8'h00);
      k++;
    end
    chk({tag, "_timeout"}, k < limit, 1);
    drive(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] dir_bytes [3];
    logic [10:0] dir_frames [3];
    logic [7:0] burst [3];
    int k;
    int snap;
    dir_bytes  = '{8'h1C, 8'h00, 8'hFF};
    dir_frames = '{11'h438, 11'h600, 11'h7FE};
    burst      = '{8'hF0, 8'h1C, 8'h5A};

    n_reset  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_line", ps2_clk_out, 1);
    chk("rst_dat_line", ps2_dat_out, 1);
    n_reset = 1'b1;
    repeat (2) drive(1'b0, 8'h00);

    // Directed single bytes with known frame images.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dir_bytes[i]);
      drive(1'b0, 8'h00);
      wait_idle(400, "single");
      chk("single_frame_image", last_frame, dir_frames[i]);
    end

    // Back-to-back burst.
    for (int i = 0; i < 3; i++) drive(1'b1, burst[i]);
    drive(1'b0, 8'h00);
    wait_idle(1000, "burst");
    chk("burst_last_image", last_frame[8:1], 8'h5A);

    // Fill past capacity while the first frame is still on its start bit.
    ovf_seen = 0;
    max_cnt  = 0;
    for (int i = 0; i < 18; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00);
    chk("fill_max_count", max_cnt, DEPTH);
    wait_idle(5000, "fill");
    chk("fill_overflow_pulses", ovf_seen, 1);

    // Random traffic, including one dense burst that overruns the FIFO.
    for (int i = 0; i < 2000; i++) begin
      if (i >= 1000 && i < 1020) drive(1'b1, 8'($urandom));
      else drive($urandom_range(0, 49) == 0, 8'($urandom));
    end
    drive(1'b0, 8'h00);
    wait_idle(5000, "random");

    // Reset in the middle of bit 5 with bytes still queued.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom));
    k = 0;
    while (nbits < 6 && k < 2000) begin
      drive(1'b0, 8'h00);
      k++;
    end
    chk("reach_bit5_timeout", k < 2000, 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("abort_clk_line", ps2_clk_out, 1);
    chk("abort_dat_line", ps2_dat_out, 1);
    chk("abort_fifo_count", fifo_count, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    n_reset = 1'b1;
    snap = fall_cnt;
    repeat (300) drive(1'b0, 8'h00);
    chk("no_edges_after_reset", fall_cnt - snap, 0);
    chk("decoder_idle_at_end", nbits, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
